// File: rtl/pueo_dual_envelope_trigger_if.sv
// ---------------------------------------------------------------------------
// pueo_dual_envelope_trigger_if
// Bundles the squared-sample inputs, threshold load strobes, envelopes and
// trigger bits of the dual-beam envelope trigger.
//   squareA_i / squareB_i : NSAMP packed squares per beam, sample k at
//                           bits [SQ_BITS*k +: SQ_BITS]
//   thresh_i              : threshold word per beam, beam b at
//                           bits [THRESH_BITS*b +: THRESH_BITS]
//   thresh_wr_i           : per-beam shadow shift-in strobe
//   thresh_update_i       : per-beam shadow->active commit strobe
//   envelopeA_o/B_o       : registered per-beam sum of squares
//   trigger_o             : bit [NTHRESH*b+k] = envelope_b > active[b][k]
// There is no valid/ready handshake: every strobe acts on the edge where it
// is high, and outputs are plain registered values sampled every clock.
// master = producer of samples/strobes, slave = the trigger block.
// ---------------------------------------------------------------------------
interface pueo_dual_envelope_trigger_if #(
   parameter int NSAMP       = 8,
   parameter int SQ_BITS     = 14,
   parameter int ENV_BITS    = 17,
   parameter int THRESH_BITS = 18,
   parameter int NTHRESH     = 2
);
   localparam int NBEAM = 2;

   logic [NSAMP*SQ_BITS-1:0]       squareA_i;
   logic [NSAMP*SQ_BITS-1:0]       squareB_i;
   logic [NBEAM*THRESH_BITS-1:0]   thresh_i;
   logic [NBEAM-1:0]               thresh_wr_i;
   logic [NBEAM-1:0]               thresh_update_i;
   logic [ENV_BITS-1:0]            envelopeA_o;
   logic [ENV_BITS-1:0]            envelopeB_o;
   logic [NBEAM*NTHRESH-1:0]       trigger_o;

   modport master (
      output squareA_i, squareB_i, thresh_i, thresh_wr_i, thresh_update_i,
      input  envelopeA_o, envelopeB_o, trigger_o
   );

   modport slave (
      input  squareA_i, squareB_i, thresh_i, thresh_wr_i, thresh_update_i,
      output envelopeA_o, envelopeB_o, trigger_o
   );
endinterface

// File: rtl/pueo_dual_envelope_trigger.sv
// ---------------------------------------------------------------------------
// pueo_dual_envelope_trigger
// Two-beam power detector following the beamformer/squarer. Each clock the
// NSAMP squares of each beam are summed into an envelope (two register
// stages) and the envelope is compared against NTHRESH programmable
// thresholds per beam (one more register stage): squares -> trigger = 3 clk.
// Thresholds are shifted into a per-beam shadow chain and committed to the
// active set atomically by an update strobe.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : pueo_dual_envelope_trigger_if slave modport (samples, threshold
//            load strobes, envelopes, trigger bits)
// ---------------------------------------------------------------------------
module pueo_dual_envelope_trigger #(
   parameter int NSAMP       = 8,
   parameter int SQ_BITS     = 14,
   parameter int ENV_BITS    = 17,
   parameter int THRESH_BITS = 18,
   parameter int NTHRESH     = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   pueo_dual_envelope_trigger_if.slave   bus
);
   localparam int NBEAM     = 2;
   localparam int NPAIR     = NSAMP / 2;
   localparam int PAIR_BITS = SQ_BITS + 1;
   // All-ones threshold can never be exceeded by a zero-extended envelope.
   localparam logic [THRESH_BITS-1:0] THRESH_NEVER = '1;

   logic [NSAMP*SQ_BITS-1:0]  sq_w [NBEAM];

   logic [PAIR_BITS-1:0]      pair_q   [NBEAM][NPAIR];
   logic [PAIR_BITS-1:0]      pair_d   [NBEAM][NPAIR];
   logic [ENV_BITS-1:0]       env_q    [NBEAM];
   logic [ENV_BITS-1:0]       env_d    [NBEAM];
   logic [THRESH_BITS-1:0]    shadow_q [NBEAM][NTHRESH];
   logic [THRESH_BITS-1:0]    shadow_d [NBEAM][NTHRESH];
   logic [THRESH_BITS-1:0]    active_q [NBEAM][NTHRESH];
   logic [THRESH_BITS-1:0]    active_d [NBEAM][NTHRESH];
   logic [NBEAM*NTHRESH-1:0]  trig_q;
   logic [NBEAM*NTHRESH-1:0]  trig_d;

   assign sq_w[0] = bus.squareA_i;
   assign sq_w[1] = bus.squareB_i;

   // Envelope pipeline: stage 1 pair sums, stage 2 full sum.
   always_comb begin
      for (int b = 0; b < NBEAM; b++) begin
         for (int p = 0; p < NPAIR; p++) begin
            pair_d[b][p] = PAIR_BITS'(sq_w[b][(2*p)*SQ_BITS +: SQ_BITS])
                         + PAIR_BITS'(sq_w[b][(2*p+1)*SQ_BITS +: SQ_BITS]);
         end
         env_d[b] = '0;
         for (int p = 0; p < NPAIR; p++) begin
            env_d[b] = env_d[b] + ENV_BITS'(pair_q[b][p]);
         end
      end
   end

   // Threshold load. The commit reads shadow_q, so a write on the same edge
   // commits the pre-shift contents and the shift still happens.
   always_comb begin
      for (int b = 0; b < NBEAM; b++) begin
         for (int k = 0; k < NTHRESH; k++) begin
            shadow_d[b][k] = shadow_q[b][k];
            active_d[b][k] = active_q[b][k];
            if (bus.thresh_update_i[b]) begin
               active_d[b][k] = shadow_q[b][k];
            end
         end
         if (bus.thresh_wr_i[b]) begin
            shadow_d[b][0] = bus.thresh_i[b*THRESH_BITS +: THRESH_BITS];
            for (int k = 1; k < NTHRESH; k++) begin
               shadow_d[b][k] = shadow_q[b][k-1];
            end
         end
      end
   end

   // Strictly-greater compare of the zero-extended envelope.
   always_comb begin
      trig_d = '0;
      for (int b = 0; b < NBEAM; b++) begin
         for (int k = 0; k < NTHRESH; k++) begin
            trig_d[b*NTHRESH + k] = THRESH_BITS'(env_q[b]) > active_q[b][k];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < NBEAM; b++) begin
            for (int p = 0; p < NPAIR; p++) begin
               pair_q[b][p] <= '0;
            end
            env_q[b] <= '0;
            for (int k = 0; k < NTHRESH; k++) begin
               shadow_q[b][k] <= THRESH_NEVER;
               active_q[b][k] <= THRESH_NEVER;
            end
         end
         trig_q <= '0;
      end else begin
         pair_q   <= pair_d;
         env_q    <= env_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         trig_q   <= trig_d;
      end
   end

   assign bus.envelopeA_o = env_q[0];
   assign bus.envelopeB_o = env_q[1];
   assign bus.trigger_o   = trig_q;

endmodule

// File: tb/tb_pueo_dual_envelope_trigger.sv
module tb_pueo_dual_envelope_trigger;
   logic clk = 1'b0;
   logic rst = 1'b1;

   pueo_dual_envelope_trigger_if bus ();

   pueo_dual_envelope_trigger dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Sums captured per edge, newest last; the envelope shows the sum captured
   // one edge earlier and the trigger compares the one before that.
   int ha[$];
   int hb[$];
   int shadow_m [2][2];
   int active_m [2][2];
   int exp_env_a, exp_env_b;
   logic [3:0] exp_trig;

   function automatic int sum_of(input logic [111:0] v);
      int s = 0;
      for (int k = 0; k < 8; k++) s += int'(v[14*k +: 14]);
      return s;
   endfunction

   task automatic model_reset();
      ha = {0, 0, 0};
      hb = {0, 0, 0};
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 2; k++) begin
            shadow_m[b][k] = 'h3FFFF;
            active_m[b][k] = 'h3FFFF;
         end
      exp_env_a = 0;
      exp_env_b = 0;
      exp_trig  = '0;
   endtask

   task automatic model_edge(input logic [111:0] a, input logic [111:0] b,
                             input logic [35:0] th, input logic [1:0] wr,
                             input logic [1:0] upd);
      int n;
      int env_now [2];
      n = ha.size();
      env_now[0] = ha[n-2];
      env_now[1] = hb[n-2];
      for (int bm = 0; bm < 2; bm++)
         for (int k = 0; k < 2; k++)
            exp_trig[2*bm+k] = (env_now[bm] > active_m[bm][k]);
      exp_env_a = ha[n-1];
      exp_env_b = hb[n-1];
      ha.push_back(sum_of(a));
      hb.push_back(sum_of(b));
      void'(ha.pop_front());
      void'(hb.pop_front());
      for (int bm = 0; bm < 2; bm++) begin
         if (upd[bm]) begin
            active_m[bm][0] = shadow_m[bm][0];
            active_m[bm][1] = shadow_m[bm][1];
         end
         if (wr[bm]) begin
            shadow_m[bm][1] = shadow_m[bm][0];
            shadow_m[bm][0] = int'(th[18*bm +: 18]);
         end
      end
   endtask

   // ---------------- driver ----------------
   function automatic logic [111:0] mk(input logic [1:0] pat, input logic [13:0] s0);
      logic [111:0] v;
      v = '0;
      case (pat)
         2'd1: for (int k = 0; k < 8; k++) v[14*k +: 14] = 14'((k+1)*(k+1));
         2'd2: v = '1;
         default: v[13:0] = s0;
      endcase
      return v;
   endfunction

   task automatic step(input logic [111:0] a, input logic [111:0] b,
                       input logic [35:0] th, input logic [1:0] wr,
                       input logic [1:0] upd);
      bus.squareA_i       = a;
      bus.squareB_i       = b;
      bus.thresh_i        = th;
      bus.thresh_wr_i     = wr;
      bus.thresh_update_i = upd;
      model_edge(a, b, th, wr, upd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step('0, '0, '0, 2'b00, 2'b00);
   endtask

   task automatic wr_both(input logic [17:0] t);
      step('0, '0, {t, t}, 2'b11, 2'b00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.squareA_i = '0; bus.squareB_i = '0; bus.thresh_i = '0;
      bus.thresh_wr_i = '0; bus.thresh_update_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [1:0]  pat;   // 0: sample0=s0 rest 0, 1: squares 1..64, 2: all max
      logic [13:0] s0;
      logic [1:0]  wr;
      logic [1:0]  upd;
      logic [17:0] th;    // same word to both beams
      logic [16:0] env;   // expected envelope (both beams) after this edge
      logic [3:0]  trig;  // expected trigger after this edge
   } vec_t;

   vec_t tbl [34];

   initial begin
      logic [111:0] va, vb;
      logic [35:0]  th;
      logic [1:0]   wr, upd;

      tbl[0]  = '{2'd1, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[1]  = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd204, 4'h0};
      tbl[2]  = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[3]  = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[4]  = '{2'd0, 14'd0,   2'd3, 2'd0, 18'd10,  17'd0,   4'h0};
      tbl[5]  = '{2'd0, 14'd0,   2'd3, 2'd0, 18'd200, 17'd0,   4'h0};
      tbl[6]  = '{2'd0, 14'd0,   2'd0, 2'd3, 18'd0,   17'd0,   4'h0};
      tbl[7]  = '{2'd1, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[8]  = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd204, 4'h0};
      tbl[9]  = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hF};
      tbl[10] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[11] = '{2'd0, 14'd200, 2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[12] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd200, 4'h0};
      tbl[13] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hA};
      tbl[14] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[15] = '{2'd0, 14'd0,   2'd3, 2'd0, 18'd5,   17'd0,   4'h0};
      tbl[16] = '{2'd0, 14'd100, 2'd3, 2'd0, 18'd5,   17'd0,   4'h0};
      tbl[17] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd100, 4'h0};
      tbl[18] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hA};
      tbl[19] = '{2'd0, 14'd0,   2'd0, 2'd3, 18'd0,   17'd0,   4'h0};
      tbl[20] = '{2'd1, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[21] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd204, 4'h0};
      tbl[22] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hF};
      tbl[23] = '{2'd0, 14'd7,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[24] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd7,   4'h0};
      tbl[25] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hF};
      tbl[26] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      // write and update together: active takes the pre-shift shadow {5,5}
      tbl[27] = '{2'd0, 14'd0,   2'd3, 2'd3, 18'd300, 17'd0,   4'h0};
      tbl[28] = '{2'd1, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[29] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd204, 4'h0};
      tbl[30] = '{2'd0, 14'd0,   2'd0, 2'd3, 18'd0,   17'd0,   4'hF};
      tbl[31] = '{2'd1, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'h0};
      tbl[32] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd204, 4'h0};
      tbl[33] = '{2'd0, 14'd0,   2'd0, 2'd0, 18'd0,   17'd0,   4'hA};

      do_reset();
      check("reset_envA", 32'(bus.envelopeA_o), 32'd0);
      check("reset_envB", 32'(bus.envelopeB_o), 32'd0);
      check("reset_trig", 32'(bus.trigger_o),   32'd0);

      // ---- table: basic pulse, load, strict compare, shadow/commit ----
      for (int i = 0; i < 34; i++) begin
         va = mk(tbl[i].pat, tbl[i].s0);
         step(va, va, {tbl[i].th, tbl[i].th}, tbl[i].wr, tbl[i].upd);
         check($sformatf("tbl%0d_envA", i), 32'(bus.envelopeA_o), 32'(tbl[i].env));
         check($sformatf("tbl%0d_envB", i), 32'(bus.envelopeB_o), 32'(tbl[i].env));
         check($sformatf("tbl%0d_trig", i), 32'(bus.trigger_o),   32'(tbl[i].trig));
      end

      // ---- full-scale envelope, thresholds just below / at the maximum ----
      wr_both(18'd131064);
      wr_both(18'd131063);
      step('0, '0, '0, 2'b00, 2'b11);
      step(mk(2'd2, 14'd0), mk(2'd2, 14'd0), '0, 2'b00, 2'b00);
      idle();
      check("max_envA", 32'(bus.envelopeA_o), 32'd131064);
      check("max_envB", 32'(bus.envelopeB_o), 32'd131064);
      idle();
      check("max_trig", 32'(bus.trigger_o), 32'h5);
      idle();
      check("max_trig_clear", 32'(bus.trigger_o), 32'h0);

      // ---- independent beams: only beam B reloaded and committed ----
      step('0, '0, {18'd0, 18'd0}, 2'b10, 2'b00);
      step('0, '0, {18'd0, 18'd0}, 2'b10, 2'b00);
      step('0, '0, '0, 2'b00, 2'b10);
      step(mk(2'd0, 14'd1), mk(2'd0, 14'd1), '0, 2'b00, 2'b00);
      idle();
      idle();
      check("beamB_only_trig", 32'(bus.trigger_o), 32'hC);

      // ---- reset in the middle of a pulse ----
      wr_both(18'd10);
      wr_both(18'd10);
      step('0, '0, '0, 2'b00, 2'b11);
      step(mk(2'd1, 14'd0), mk(2'd1, 14'd0), '0, 2'b00, 2'b00);
      idle();
      check("pre_rst_envA", 32'(bus.envelopeA_o), 32'd204);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_envA", 32'(bus.envelopeA_o), 32'd0);
      check("rst_async_envB", 32'(bus.envelopeB_o), 32'd0);
      check("rst_async_trig", 32'(bus.trigger_o),   32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_trig", 32'(bus.trigger_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(mk(2'd1, 14'd0), mk(2'd1, 14'd0), '0, 2'b00, 2'b00);
      idle();
      check("post_rst_envA", 32'(bus.envelopeA_o), 32'd204);
      idle();
      check("post_rst_trig", 32'(bus.trigger_o), 32'd0);
      idle();

      // ---- randomized run against the reference model ----
      for (int i = 0; i < 400; i++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         va = '0;
         vb = '0;
         for (int k = 0; k < 8; k++) begin
            if (mode == 0) begin
               va[14*k +: 14] = 14'($urandom_range(0, 16383));
               vb[14*k +: 14] = 14'($urandom_range(0, 16383));
            end else if (mode == 1) begin
               va[14*k +: 14] = 14'($urandom_range(0, 63));
               vb[14*k +: 14] = 14'($urandom_range(0, 63));
            end
         end
         for (int bm = 0; bm < 2; bm++) begin
            case ($urandom_range(0, 3))
               0: th[18*bm +: 18] = 18'($urandom_range(0, 131071));
               1: th[18*bm +: 18] = 18'($urandom_range(0, 600));
               2: th[18*bm +: 18] = 18'h3FFFF;
               default: th[18*bm +: 18] = 18'($urandom_range(0, 20));
            endcase
         end
         wr  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         upd = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         step(va, vb, th, wr, upd);
         check("rnd_envA", 32'(bus.envelopeA_o), 32'(exp_env_a));
         check("rnd_envB", 32'(bus.envelopeB_o), 32'(exp_env_b));
         check("rnd_trig", 32'(bus.trigger_o),   32'(exp_trig));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
